// File: rtl/line_fill_pkg.sv
// Shared types, AXI constants and geometry helpers for the line fill unit.
package line_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Number of address bits covered by one cache line.
    function automatic int line_off_bits(input int line_beats, input int data_width);
        return $clog2(line_beats * data_width / 8);
    endfunction

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered last-grant pointer.
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] last_q;
    logic [PW-1:0] grant_idx;
    logic          found;
    int            cand;

    // Search starts at the index just after the last winner.
    always_comb begin
        grant     = '0;
        grant_idx = last_q;
        found     = 1'b0;
        cand      = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last_q) + i) % N_REQ;
            if (!found && req[PW'(cand)]) begin
                found             = 1'b1;
                grant[PW'(cand)]  = 1'b1;
                grant_idx         = PW'(cand);
            end
        end
    end

    // Reset points at the highest index so index 0 is favoured first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= PW'(N_REQ - 1);
        end else if (advance) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/line_fill_unit.sv
// Cache-line refill engine: arbitrates cache misses, issues one AXI4 INCR burst
// per line, assembles the beats and returns the line with a one-cycle pulse.
module line_fill_unit
    import line_fill_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_BEATS = 16,
    parameter int N_REQ      = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0]      req_addr,
    output logic [N_REQ-1:0]                 req_ready,
    output logic [N_REQ-1:0]                 resp_valid,
    output logic [LINE_BEATS*DATA_WIDTH-1:0] resp_data,
    output logic                             resp_err,
    output logic                             busy,
    output state_t                           fsm_state,
    output logic [ID_WIDTH-1:0]              m_axi_arid,
    output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic [7:0]                       m_axi_arlen,
    output logic [2:0]                       m_axi_arsize,
    output logic [1:0]                       m_axi_arburst,
    output logic                             m_axi_arlock,
    output logic [3:0]                       m_axi_arcache,
    output logic [2:0]                       m_axi_arprot,
    output logic                             m_axi_arvalid,
    input  logic                             m_axi_arready,
    input  logic [ID_WIDTH-1:0]              m_axi_rid,
    input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic [1:0]                       m_axi_rresp,
    input  logic                             m_axi_rlast,
    input  logic                             m_axi_rvalid,
    output logic                             m_axi_rready
);

    localparam int GW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW  = $clog2(LINE_BEATS + 1);
    localparam int BW  = $clog2(LINE_BEATS);
    localparam int OFF = line_off_bits(LINE_BEATS, DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));
    localparam logic [2:0]            ARSIZE    = axi_size(DATA_WIDTH);

    state_t                  state_q, state_d;
    logic [GW-1:0]           gnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CW-1:0]           cnt_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   line_buf [LINE_BEATS];

    logic [N_REQ-1:0]        grant;
    logic [GW-1:0]           sel_idx;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    unused_rid;

    // Single burst outstanding, so the returned ID carries no information.
    assign unused_rid = ^m_axi_rid;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (|req_ready),
        .grant   (grant)
    );

    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_idx  = GW'(i);
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Handshake rule: a transfer happens on any cycle where valid and ready are
    // both high; arvalid is held with stable AR fields until arready is seen.
    always_comb begin
        state_d       = state_q;
        req_ready     = '0;
        resp_valid    = '0;
        resp_err      = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (reset) req_ready = grant;
                if (|req_valid) state_d = ADDR;
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = DATA;
            end
            DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && m_axi_rlast) state_d = RESP;
            end
            RESP: begin
                resp_valid[gnt_q] = 1'b1;
                resp_err          = err_q;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q  <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            for (int k = 0; k < LINE_BEATS; k++) line_buf[k] <= '0;
        end else begin
            if (|req_ready) begin
                gnt_q  <= sel_idx;
                addr_q <= sel_addr & LINE_MASK;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end
            if (state_q == DATA && m_axi_rvalid) begin
                // Counter saturates at LINE_BEATS; overflow beats only flag an error.
                if (cnt_q < CW'(LINE_BEATS)) begin
                    line_buf[cnt_q[BW-1:0]] <= m_axi_rdata;
                    cnt_q                   <= cnt_q + 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
                if (m_axi_rresp != RESP_OKAY) err_q <= 1'b1;
                if (m_axi_rlast && cnt_q != CW'(LINE_BEATS - 1)) err_q <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < LINE_BEATS; k++) begin : g_pack
        assign resp_data[k*DATA_WIDTH +: DATA_WIDTH] = line_buf[k];
    end

    assign busy          = (state_q != IDLE);
    assign fsm_state     = state_q;
    assign m_axi_arid    = {{(ID_WIDTH-GW){1'b0}}, gnt_q};
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = m_axi_arvalid ? 8'(LINE_BEATS - 1) : 8'd0;
    assign m_axi_arsize  = m_axi_arvalid ? ARSIZE : 3'd0;
    assign m_axi_arburst = m_axi_arvalid ? BURST_INCR : 2'b00;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;

endmodule

// File: doc/line_fill_unit.md
Name: line_fill_unit

Overview:
Cache-line refill engine between the instruction/data caches and the AXI4 master read channels (AR/R) of the core's bus port.
- Arbitrates refill requests from N_REQ caches.
- Issues one INCR burst per line and assembles the returned beats into a full line.
- Returns the line to the winning cache with a one-cycle response pulse.
- Exactly one burst is outstanding at a time.

Parameters:
ID_WIDTH, 13, width of arid/rid
ADDR_WIDTH, 64, physical address width
DATA_WIDTH, 64, AXI data beat width
LINE_BEATS, 16, beats per cache line (line = LINE_BEATS*DATA_WIDTH bits)
N_REQ, 2, number of requesting caches (index 0 = data cache, index 1 = instruction cache)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  refill request per cache; held until req_ready seen
req_addr  in  N_REQ*ADDR_WIDTH  miss address per cache, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
req_ready  out  N_REQ  one-hot grant pulse; address is latched this cycle
resp_valid  out  N_REQ  one-hot, one-cycle line-delivered pulse
resp_data  out  LINE_BEATS*DATA_WIDTH  assembled line; beat k in [k*DATA_WIDTH +: DATA_WIDTH]
resp_err  out  1  qualifies resp_valid; bad rresp or beat-count mismatch
busy  out  1  high in any state other than IDLE
m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  AXI4 widths  read address channel
m_axi_arready  in  1
m_axi_rid/rdata/rresp/rlast/rvalid  in  AXI4 widths  read data channel
m_axi_rready  out  1

Behaviour:
- Reset value of every output is 0. Asserting reset clears all registers.
  - FSM returns to IDLE and the round-robin pointer favours index 0.
  - A burst in progress is abandoned; the bus is reset with the core.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any req_valid is high, grant one requester via round-robin: favour the index after the last granted.
  - Drive req_ready[g]=1 for that cycle only. Latch g and the line-aligned address.
  - Line-aligned address = req_addr[g] with the low log2(LINE_BEATS*DATA_WIDTH/8) bits cleared (7 bits at defaults).
  - Clear the beat counter and the error flag, then go to ADDR.
- ADDR:
  - arvalid=1 with constant fields: arlen=LINE_BEATS-1, arsize=log2(DATA_WIDTH/8), arburst=2'b01 (INCR), arlock=0, arcache=0, arprot=0.
  - arid = g, zero-extended to ID_WIDTH.
  - arvalid and all AR fields stay stable until arready is seen. arvalid never drops without a handshake.
  - On arvalid&&arready, go to DATA.
- DATA:
  - rready=1 continuously. Each rvalid cycle is one beat.
  - While counter < LINE_BEATS, the beat is stored at position counter and the counter increments. The counter saturates at LINE_BEATS; extra beats are discarded and set the error flag.
  - rresp != 2'b00 on any beat sets the sticky error flag.
  - On a beat with rlast: if total beats != LINE_BEATS, set the error flag. Go to RESP.
  - Gaps in rvalid are legal and stall collection without penalty.
  - rid is not compared, since a single burst is outstanding.
- RESP:
  - resp_valid[g]=1 for exactly one cycle. resp_err = error flag. resp_data = line buffer.
  - Advance the round-robin pointer to g, then go to IDLE.
  - resp_data is guaranteed only while resp_valid is high; the buffer is overwritten by the next fill.
- Latency, zero-wait bus: grant at T; AR handshake at T+1; beats T+2..T+17; resp_valid at T+18 (the cycle after rlast). Next grant no earlier than T+19.
- Simultaneous events:
  - Requests arriving outside IDLE wait; no queueing beyond each requester's held req_valid.
  - A requester that drops req_valid before grant is simply not granted.
  - With both requesters continuously valid, grants strictly alternate.

Decomposition:
- Package line_fill_pkg:
  - state enum typedef (IDLE/ADDR/DATA/RESP)
  - AXI constants BURST_INCR=2'b01, RESP_OKAY=2'b00
  - helper functions for line-offset bits and arsize from DATA_WIDTH
- Sub-module rr_arbiter (N_REQ-wide):
  - inputs: request vector, advance strobe
  - output: one-hot grant
  - holds the last-grant pointer; combinational grant, registered pointer.
- All other logic stays in line_fill_unit.

Test Plan:
- Single request from index 1, addr 0x8000_1234, zero-wait slave returning beats 0..15 with rdata = 0x1000+k -> araddr=0x8000_1200, arlen=15, arsize=3, arburst=1, arid=1; resp_valid[1] at grant+18; resp_data[k*64+:64]=0x1000+k; resp_err=0.
- Both req_valid held high for four fills -> grants in order 0,1,0,1; each req_ready a single-cycle pulse; never both resp_valid bits high.
- arready held low 5 cycles -> arvalid, araddr and arlen stable throughout; one handshake; resp_valid 5 cycles later than the zero-wait case.
- rvalid gapped on alternate cycles; rresp=2'b10 on beat 7 -> all 16 beats stored correctly; resp_err=1 with resp_valid.
- rlast asserted on beat 10 (11 beats) -> resp_valid the next cycle with resp_err=1; FSM back in IDLE. A 17-beat burst likewise gives resp_err=1 with beats 0..15 intact.
- reset driven low during DATA beat 6 -> all outputs 0 immediately; after release, a new request on index 0 is granted first and completes normally.
